// File: rtl/a_or_b_if.sv
// rtl/a_or_b_if.sv - operand/function/result bundle for the a_or_b ALU
// The master drives operands and function select; the slave returns registered results.
interface a_or_b_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       fxn;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output A,
    output B,
    output fxn,
    input  out,
    input  cout,
    input  ovf,
    input  zero
  );

  modport slave (
    input  A,
    input  B,
    input  fxn,
    output out,
    output cout,
    output ovf,
    output zero
  );
endinterface

// File: rtl/a_or_b.sv
// rtl/a_or_b.sv - single-cycle registered ALU with a shared ripple-carry add/sub
// Results are selected combinationally and captured every rising edge.
module a_or_b #(
  parameter int WIDTH = 6
) (
  input  logic    clk,
  input  logic    rst_n,
  a_or_b_if.slave bus
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             arith_ovf;

  logic [WIDTH-1:0] nxt_out;
  logic             nxt_cout;
  logic             nxt_ovf;

  // Subtract reuses the adder as A + ~B + 1.
  assign sub      = (bus.fxn == 3'b110);
  assign b_eff    = sub ? ~bus.B : bus.B;
  assign carry[0] = sub;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]     = bus.A[i] ^ b_eff[i] ^ carry[i];
      assign carry[i+1] = (bus.A[i] & b_eff[i]) | (carry[i] & (bus.A[i] ^ b_eff[i]));
    end
  endgenerate

  // Comparing against the effective addend covers both add and subtract overflow rules.
  assign arith_ovf = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);

  always_comb begin
    nxt_out  = '0;
    nxt_cout = 1'b0;
    nxt_ovf  = 1'b0;
    case (bus.fxn)
      3'b000: nxt_out = bus.A;
      3'b001: nxt_out = bus.B;
      3'b010: nxt_out = bus.A & bus.B;
      3'b011: nxt_out = bus.A | bus.B;
      3'b100: nxt_out = bus.A ^ bus.B;
      3'b101, 3'b110: begin
        nxt_out  = sum;
        nxt_cout = carry[WIDTH];
        nxt_ovf  = arith_ovf;
      end
      3'b111: nxt_out = ~bus.A;
      default: nxt_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b1;
    end else begin
      bus.out  <= nxt_out;
      bus.cout <= nxt_cout;
      bus.ovf  <= nxt_ovf;
      bus.zero <= (nxt_out == '0);
    end
  end

endmodule

// File: tb/tb_a_or_b.sv
// tb/tb_a_or_b.sv - directed and random self-checking bench for a_or_b
// Expected values are hand-computed or come from an integer reference model.
module tb_a_or_b;

  localparam int W = 6;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  a_or_b_if #(.WIDTH(W)) bus ();

  a_or_b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] e_out,
                       input logic e_cout, input logic e_ovf, input logic e_zero);
    logic [W+2:0] obs;
    logic [W+2:0] exp;
    obs = {bus.out, bus.cout, bus.ovf, bus.zero};
    exp = {e_out, e_cout, e_ovf, e_zero};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: out/cout/ovf/zero observed %0d/%b/%b/%b expected %0d/%b/%b/%b",
             tag, bus.out, bus.cout, bus.ovf, bus.zero, e_out, e_cout, e_ovf, e_zero);
    end
  endtask

  // Drive at the falling edge, then sample one full cycle later.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] f, input logic [W-1:0] e_out,
                      input logic e_cout, input logic e_ovf, input logic e_zero);
    bus.A   = a;
    bus.B   = b;
    bus.fxn = f;
    @(negedge clk);
    check(tag, e_out, e_cout, e_ovf, e_zero);
  endtask

  // Integer-arithmetic reference: {out, cout, ovf, zero}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] f);
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           s;
    int           sv;
    r  = '0;
    c  = 1'b0;
    o  = 1'b0;
    s  = 0;
    sv = 0;
    case (f)
      3'd0: r = a;
      3'd1: r = b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        s  = int'(a) + int'(b);
        r  = W'(s);
        c  = (s >= (1 << W));
        sv = int'($signed(a)) + int'($signed(b));
        o  = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
      end
      3'd6: begin
        s  = int'(a) - int'(b);
        r  = W'(s);
        c  = (int'(a) >= int'(b));
        sv = int'($signed(a)) - int'($signed(b));
        o  = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
      end
      default: r = ~a;
    endcase
    return {r, c, o, (r == '0)};
  endfunction

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2:0]   rf;
    logic [W+2:0] e;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    bus.A       = 6'd63;
    bus.B       = 6'd63;
    bus.fxn     = 3'b101;

    // Asynchronous reset observed before any clock edge.
    #2 rst_n = 1'b0;
    #1 check("reset_async", 6'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("reset_hold", 6'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    step("add_5_3",      6'd5,  6'd3, 3'b101, 6'd8,  1'b0, 1'b0, 1'b0);
    step("add_wrap",     6'd63, 6'd1, 3'b101, 6'd0,  1'b1, 1'b0, 1'b1);
    step("add_ovf",      6'd31, 6'd1, 3'b101, 6'd32, 1'b0, 1'b1, 1'b0);
    step("add_neg_ovf",  6'd32, 6'd32, 3'b101, 6'd0, 1'b1, 1'b1, 1'b1);
    step("sub_borrow",   6'd3,  6'd5, 3'b110, 6'd62, 1'b0, 1'b0, 1'b0);
    step("sub_5_3",      6'd5,  6'd3, 3'b110, 6'd2,  1'b1, 1'b0, 1'b0);
    step("sub_ovf",      6'd32, 6'd1, 3'b110, 6'd31, 1'b1, 1'b1, 1'b0);
    step("sub_zero",     6'd0,  6'd0, 3'b110, 6'd0,  1'b1, 1'b0, 1'b1);

    step("pass_a",  6'b101010, 6'b110011, 3'b000, 6'b101010, 1'b0, 1'b0, 1'b0);
    step("pass_b",  6'b101010, 6'b110011, 3'b001, 6'b110011, 1'b0, 1'b0, 1'b0);
    step("and",     6'b101010, 6'b110011, 3'b010, 6'b100010, 1'b0, 1'b0, 1'b0);
    step("or",      6'b101010, 6'b110011, 3'b011, 6'b111011, 1'b0, 1'b0, 1'b0);
    step("xor",     6'b101010, 6'b110011, 3'b100, 6'b011001, 1'b0, 1'b0, 1'b0);
    step("not_a",   6'b101010, 6'b110011, 3'b111, 6'b010101, 1'b0, 1'b0, 1'b0);
    step("and_zero", 6'b101010, 6'b010101, 3'b010, 6'd0,     1'b0, 1'b0, 1'b1);

    step("b2b_pass", 6'd10, 6'd4, 3'b000, 6'd10, 1'b0, 1'b0, 1'b0);
    step("b2b_add",  6'd10, 6'd4, 3'b101, 6'd14, 1'b0, 1'b0, 1'b0);
    step("b2b_sub",  6'd10, 6'd4, 3'b110, 6'd6,  1'b1, 1'b0, 1'b0);
    step("b2b_not",  6'd10, 6'd4, 3'b111, 6'd53, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset between edges discards the held result.
    bus.A   = 6'd20;
    bus.B   = 6'd7;
    bus.fxn = 3'b101;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid", 6'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("reset_mid_hold", 6'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_add", 6'd27, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 21; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rf = 3'($urandom_range(0, 7));
      e  = model(ra, rb, rf);
      step($sformatf("rand_%0d", n), ra, rb, rf, e[W+2:3], e[2], e[1], e[0]);
      repeat (19) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a_or_b.md
A_OR_B -- requirements
Module: a_or_b

Interface
REQ-001 Parameter: WIDTH, default 6, operand and result width in bits; all values below assume WIDTH=6.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  WIDTH  operand A, unsigned/two's-complement.
REQ-005 B  input  WIDTH  operand B, unsigned/two's-complement.
REQ-006 fxn  input  3  function select.
REQ-007 out  output  WIDTH  registered result.
REQ-008 cout  output  1  registered carry-out (add/sub only, else 0).
REQ-009 ovf  output  1  registered signed overflow (add/sub only, else 0).
REQ-010 zero  output  1  registered flag, 1 when the registered out == 0.

Function
REQ-011 Result selection by fxn SHALL be combinational from A, B, fxn; out/cout/ovf/zero SHALL be captured on each rising clk edge (latency exactly 1 cycle, new result every cycle, no handshake).
REQ-012 fxn=000: out = A.
REQ-013 fxn=001: out = B.
REQ-014 fxn=010: out = A AND B (bitwise).
REQ-015 fxn=011: out = A OR B (bitwise).
REQ-016 fxn=100: out = A XOR B (bitwise).
REQ-017 fxn=101: out = (A + B) mod 2^WIDTH; cout = carry out of MSB; ovf = 1 when A, B MSBs equal and result MSB differs.
REQ-018 fxn=110: out = (A - B) mod 2^WIDTH, computed as A + ~B + 1; cout = carry out of MSB (1 = no borrow, 0 = borrow); ovf = 1 when A, B MSBs differ and result MSB differs from A MSB.
REQ-019 fxn=111: out = NOT A (bitwise).
REQ-020 Add and subtract SHALL share one WIDTH-stage ripple-carry adder of full-adder cells; subtract inverts B and sets carry-in = 1.
REQ-021 For fxn not 101/110, cout and ovf SHALL register 0.
REQ-022 zero SHALL be derived from the next-state result, so it is always consistent with out in the same cycle.
REQ-023 Wrap-around: sums/differences exceeding the range SHALL truncate to WIDTH bits with no saturation.
REQ-024 X/Z-free inputs are assumed; no internal state beyond the output registers.

Reset
REQ-025 rst_n low SHALL asynchronously force out=0, cout=0, ovf=0, zero=1, independent of clk.
REQ-026 While rst_n is low, registers SHALL hold reset values; the first capture is on the first rising clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-operation SHALL discard the pending result immediately; no partial state survives.

Verification
REQ-028 Reset: rst_n=0 with A=63, B=63, fxn=101 -> out=0, cout=0, ovf=0, zero=1 immediately, without a clock edge.
REQ-029 Add: A=5, B=3, fxn=101 -> after 1 edge out=8, cout=0, ovf=0, zero=0; add wrap A=63, B=1 -> out=0, cout=1, ovf=0, zero=1; signed overflow A=31, B=1 -> out=32, ovf=1, cout=0.
REQ-030 Subtract: A=3, B=5, fxn=110 -> out=62, cout=0 (borrow), ovf=0; A=5, B=3 -> out=2, cout=1; A=32, B=1 -> out=31, ovf=1.
REQ-031 Logic: A=6'b101010, B=6'b110011 -> fxn=000 out=101010; 001 out=110011; 010 out=100010; 011 out=111011; 100 out=011001; 111 out=010101; cout=ovf=0 in all six cases.
REQ-032 Latency/back-to-back: change fxn every cycle (000,101,110,111) with A=10, B=4 -> out sequence 10, 14, 6, 53, each one cycle after the inputs.
REQ-033 Random: 21 vectors, A, B, fxn uniform random, held 200 ns each -> out/cout/ovf/zero match a reference model of REQ-012..REQ-023 one cycle after each change.
